// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the sequence transmitter / detector family:
//   seq_state_t   - Moore FSM state encoding (IDLE, SEND, GAP, DONE)
//   SEQ_PAT_W     - default pattern length
//   SEQ_PAT_1011  - default pattern, transmitted MSB first
//   SEQ_IDX_W     - bit-index width for the default pattern
//   seq_idx_w()   - bit-index width for an arbitrary pattern length (>= 2)
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam int unsigned SEQ_PAT_W = 4;
    localparam logic [SEQ_PAT_W-1:0] SEQ_PAT_1011 = 4'b1011;
    localparam int unsigned SEQ_IDX_W = $clog2(SEQ_PAT_W);

    // Width needed to index every bit of a pat_w-bit pattern.
    function automatic int unsigned seq_idx_w(input int unsigned pat_w);
        return (pat_w > 2) ? $clog2(pat_w) : 1;
    endfunction

endpackage

// File: rtl/seq_down_ctr.sv
// -----------------------------------------------------------------------------
// seq_down_ctr
// Loadable down-counter that saturates at zero and flags the zero value.
// Load has priority over decrement.
//   clk        in  1  clock, rising edge
//   rst        in  1  asynchronous reset, active low (count clears to 0)
//   load_i     in  1  load load_val_i on the next edge
//   load_val_i in  W  value to load
//   dec_i      in  1  decrement on the next edge (held at 0 once reached)
//   count_o    out W  current count
//   zero_o     out 1  count_o == 0
// -----------------------------------------------------------------------------
module seq_down_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
// Serial pattern transmitter. Sends PATTERN MSB first, one bit per clock,
// repeated `reps` times with `gap` idle zero bits between repetitions.
//   clk    in  1      clock, rising edge
//   rst    in  1      asynchronous reset, active low
//   start  in  1      request, sampled only in IDLE
//   reps   in  CNT_W  repetition count, latched on accepted start (0 = ignore)
//   gap    in  GAP_W  zero bits between repetitions, latched on accepted start
//   abort  in  1      cancel the transfer in progress (beats start)
//   out    out 1      serial data bit
//   valid  out 1      out carries a pattern bit
//   busy   out 1      transfer in progress (SEND, GAP, DONE)
//   done   out 1      one-cycle pulse after the last bit of the last repetition
// Outputs are registered from the current state, so they trail the state by
// one cycle: start sampled at edge N puts the first bit on out at edge N+1.
// -----------------------------------------------------------------------------
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned         PAT_W   = SEQ_PAT_W,
    parameter logic [PAT_W-1:0]    PATTERN = SEQ_PAT_1011,
    parameter int unsigned         CNT_W   = 8,
    parameter int unsigned         GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      IDX_W   = seq_idx_w(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    seq_state_t       state_q;
    logic [GAP_W-1:0] gap_len_q;
    logic             out_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    // Counter controls and status
    logic             accept;
    logic             last_bit;
    logic             reps_last;
    logic             rep_boundary;
    logic             gap_exit;

    logic             idx_load;
    logic             idx_dec;
    logic [IDX_W-1:0] idx_cnt;
    logic             idx_zero;

    logic             reps_dec;
    logic [CNT_W-1:0] reps_cnt;
    logic             reps_zero_unused;

    logic             gap_load;
    logic             gap_dec;
    logic [GAP_W-1:0] gap_cnt_unused;
    logic             gap_zero;

    always_comb begin
        accept       = (state_q == IDLE) && start && (reps != '0) && !abort;
        last_bit     = (state_q == SEND) && idx_zero && !abort;
        reps_last    = (reps_cnt == CNT_W'(1));
        // Another repetition follows the bit now on the line.
        rep_boundary = last_bit && !reps_last;
        gap_exit     = (state_q == GAP) && gap_zero && !abort;

        idx_load = accept || gap_exit || (rep_boundary && (gap_len_q == '0));
        idx_dec  = (state_q == SEND) && !abort;
        reps_dec = rep_boundary;
        // The gap counter holds "cycles left after this one", so a gap of G
        // loads G-1 and leaves GAP when it reads zero.
        gap_load = rep_boundary && (gap_len_q != '0);
        gap_dec  = (state_q == GAP) && !abort;
    end

    seq_down_ctr #(.W(IDX_W)) u_idx_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (idx_load),
        .load_val_i (IDX_MSB),
        .dec_i      (idx_dec),
        .count_o    (idx_cnt),
        .zero_o     (idx_zero)
    );

    seq_down_ctr #(.W(CNT_W)) u_reps_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (reps),
        .dec_i      (reps_dec),
        .count_o    (reps_cnt),
        .zero_o     (reps_zero_unused)
    );

    seq_down_ctr #(.W(GAP_W)) u_gap_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (gap_load),
        .load_val_i (gap_len_q - GAP_W'(1)),
        .dec_i      (gap_dec),
        .count_o    (gap_cnt_unused),
        .zero_o     (gap_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gap_len_q <= '0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // An abort blanks the outputs on the same edge the FSM returns to
            // IDLE, so no stray bit or done pulse follows the cancel.
            out_q   <= (state_q == SEND) && !abort && PATTERN[idx_cnt];
            valid_q <= (state_q == SEND) && !abort;
            busy_q  <= (state_q != IDLE) && !abort;
            done_q  <= (state_q == DONE) && !abort;

            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= SEND;
                        gap_len_q <= gap;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (idx_zero) begin
                        if (reps_last) begin
                            state_q <= DONE;
                        end else if (gap_len_q != '0) begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (abort || gap_zero) begin
                        state_q <= abort ? IDLE : SEND;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter. It drives a fixed bit pattern (default 1011) MSB-first onto a single-bit line, one bit per clock. The pattern is repeated a programmable number of times, with an optional run of idle zero bits between repetitions. It is the stimulus/transmit end for the Moore sequence-detector family and feeds a detector's `in` port directly.

## Interface
- `PAT_W`, 4: pattern length in bits (≥2).
- `PATTERN`, 4'b1011: pattern transmitted, bit `PAT_W-1` first.
- `CNT_W`, 8: width of the repetition count.
- `GAP_W`, 4: width of the inter-repetition gap length.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset. Asynchronous, active-low.
- `start`  in  1: request. Sampled only in IDLE.
- `reps`  in  CNT_W: number of pattern repetitions. Latched on accepted `start`.
- `gap`  in  GAP_W: zero bits inserted between repetitions. Latched on accepted `start`.
- `abort`  in  1: cancel the transfer in progress.
- `out`  out  1: serial data bit.
- `valid`  out  1: `out` carries a pattern bit this cycle.
- `busy`  out  1: high in SEND, GAP and DONE.
- `done`  out  1: one-cycle pulse after the last bit of the last repetition.

## Operation
- Moore FSM with states IDLE, SEND, GAP, DONE. All outputs are registered and depend on state and counters only.
- While `rst`=0: state is IDLE and `out`, `valid`, `busy`, `done` are 0. Taking effect mid-transfer, reset aborts immediately with no `done`.
- IDLE:
  - `start`=1 and `reps`≠0 and `abort`=0: latch `reps` and `gap`, set bit index to `PAT_W-1`, go to SEND.
  - `start` with `reps`=0: ignored; the block stays IDLE and no `done` is produced.
- SEND: `out`=`PATTERN[idx]`, `valid`=1. The index decrements each cycle. At idx=0:
  - remaining reps = 1: go to DONE.
  - else if latched gap = 0: decrement reps, reload idx to `PAT_W-1`, stay in SEND (back-to-back, no bubble).
  - else: decrement reps, load gap counter, go to GAP.
- GAP: `out`=0, `valid`=0. Lasts exactly `gap` cycles, then go to SEND with idx=`PAT_W-1`.
- DONE: `done`=1, `out`=0, `valid`=0 for one cycle, then IDLE.
- `abort`=1 in SEND, GAP or DONE: go to IDLE on the next edge with no `done` pulse. `abort` beats `start` when both are high in the same cycle.
- `start` outside IDLE is ignored. `reps` and `gap` changes after acceptance have no effect.
- Counters are unsigned and never wrap. The reps counter decrements only on a repetition boundary and stops at 1 before DONE.

## Timing
- `start` accepted at edge N: the first pattern bit is on `out` with `valid`=1 from edge N+1.
- One repetition occupies `PAT_W` cycles. A transfer of R reps and gap G takes R·PAT_W + (R−1)·G cycles of SEND/GAP, plus 1 DONE cycle.
- `busy` rises at edge N+1 and falls at the edge ending DONE. The earliest next accepted `start` is the cycle after DONE.
- Maximum burst: reps=2^CNT_W−1, gap=2^GAP_W−1. No overflow.

## Structure
- Package `seq_pkg`:
  - state enum `seq_state_t` (IDLE, SEND, GAP, DONE), shared with the detector family;
  - default pattern constant `SEQ_PAT_1011`;
  - width constant for the bit index, `$clog2(PAT_W)`.
- One natural sub-module, `seq_down_ctr`: a loadable, saturating down-counter with a zero flag. It is instantiated three times, for bit index, gap and reps.
- The top contains the FSM and the output register.

## Test plan
- Reset, then `start` with reps=1, gap=0: `out`=1,0,1,1 on 4 consecutive cycles with `valid`=1. `done` pulses on the 5th cycle. `busy` is high for 5 cycles.
- reps=3, gap=0: 12 contiguous valid bits 101110111011. A connected non-overlapping 1011 detector asserts 3 times.
- reps=2, gap=2: bits 1011, then 2 cycles with `valid`=0 and `out`=0, then 1011, then `done`. 11 cycles total including DONE.
- `start` with reps=0: `busy`, `valid` and `done` stay 0 for 10 cycles. A second `start` asserted mid-transfer is ignored (bit count unchanged).
- `abort` on the 3rd SEND cycle of reps=2: IDLE next cycle, no `done`. A `start` in the same cycle as `abort` in IDLE is not accepted.
- `rst` pulled low mid-GAP: outputs go to 0 immediately. After release, a fresh `start` transmits a full pattern from its MSB.
